mc_controller: RTL and testbench

//  Parametrised successor to the fixed multicycle control unit of riscv32.

---
 rtl/mc_controller.sv | 336 +++++++++++++++++++++++++++++++++
 tb/tb_mc_controller.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
//  Module   : mc_controller
//  Purpose  : Multicycle RV32I control unit. A main FSM and an ALU decoder
//             drive a shared-ALU datapath. Memory accesses use a
//             variable-latency request/ready handshake. A wait-state timeout
//             ends an access that never completes and sends the FSM to TRAP.
//  Options  : `define ILLEGAL_TRAP_EN -> an illegal opcode or a reserved
//             branch funct3 goes to TRAP. When it is undefined, such an
//             instruction retires as a NOP.
//  Revision : 1.0  initial release
// ============================================================================
module mc_controller #(
   parameter int MEM_TIMEOUT = 16,   // max wait cycles per access, 0 = none
   parameter int CNT_W       = 5     // wait counter width, 2**CNT_W > MEM_TIMEOUT
) (
   input  logic       clk,
   input  logic       reset,         // synchronous, active-low
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       negative,
   input  logic       carryout,
   input  logic       overflow,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       pc_write,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [3:0] ALUControl,
   output logic [1:0] ALUSrca,
   output logic [1:0] ALUSrcb,
   output logic       RegWrite,
   output logic       trap,
   output logic [3:0] state
);

   // FSM state encoding
   localparam logic [3:0] c_FETCH    = 4'd0;
   localparam logic [3:0] c_DECODE   = 4'd1;
   localparam logic [3:0] c_MEMADR   = 4'd2;
   localparam logic [3:0] c_MEMREAD  = 4'd3;
   localparam logic [3:0] c_MEMWB    = 4'd4;
   localparam logic [3:0] c_MEMWRITE = 4'd5;
   localparam logic [3:0] c_EXECR    = 4'd6;
   localparam logic [3:0] c_EXECI    = 4'd7;
   localparam logic [3:0] c_ALUWB    = 4'd8;
   localparam logic [3:0] c_BRANCH   = 4'd9;
   localparam logic [3:0] c_JAL      = 4'd10;
   localparam logic [3:0] c_JALR     = 4'd11;
   localparam logic [3:0] c_JALRPC   = 4'd12;
   localparam logic [3:0] c_LUI      = 4'd13;
   localparam logic [3:0] c_AUIPC    = 4'd14;
   localparam logic [3:0] c_TRAP     = 4'd15;

   // RV32I major opcodes
   localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
   localparam logic [6:0] c_OP_STORE  = 7'b0100011;
   localparam logic [6:0] c_OP_R      = 7'b0110011;
   localparam logic [6:0] c_OP_I      = 7'b0010011;
   localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
   localparam logic [6:0] c_OP_JAL    = 7'b1101111;
   localparam logic [6:0] c_OP_JALR   = 7'b1100111;
   localparam logic [6:0] c_OP_LUI    = 7'b0110111;
   localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;

   // ALU operation codes
   localparam logic [3:0] c_ALU_ADD  = 4'b0000;
   localparam logic [3:0] c_ALU_SUB  = 4'b0001;
   localparam logic [3:0] c_ALU_AND  = 4'b0010;
   localparam logic [3:0] c_ALU_OR   = 4'b0011;
   localparam logic [3:0] c_ALU_XOR  = 4'b0100;
   localparam logic [3:0] c_ALU_SLL  = 4'b0101;
   localparam logic [3:0] c_ALU_SRL  = 4'b0110;
   localparam logic [3:0] c_ALU_SRA  = 4'b0111;
   localparam logic [3:0] c_ALU_SLT  = 4'b1000;
   localparam logic [3:0] c_ALU_SLTU = 4'b1001;

   // Mux select encodings
   localparam logic [1:0] c_SRCA_PC   = 2'b00;
   localparam logic [1:0] c_SRCA_OLD  = 2'b01;
   localparam logic [1:0] c_SRCA_RD1  = 2'b10;
   localparam logic [1:0] c_SRCA_ZERO = 2'b11;
   localparam logic [1:0] c_SRCB_WD   = 2'b00;
   localparam logic [1:0] c_SRCB_IMM  = 2'b01;
   localparam logic [1:0] c_SRCB_FOUR = 2'b10;
   localparam logic [1:0] c_RES_ALUOUT = 2'b00;
   localparam logic [1:0] c_RES_DATA   = 2'b01;
   localparam logic [1:0] c_RES_ALURES = 2'b10;

   localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(MEM_TIMEOUT);

   // Where an illegal instruction goes after DECODE
`ifdef ILLEGAL_TRAP_EN
   localparam logic [3:0] c_ILLEGAL_NEXT = c_TRAP;
`else
   localparam logic [3:0] c_ILLEGAL_NEXT = c_FETCH;
`endif

   logic [3:0]       r_state;
   logic [3:0]       w_state_next;
   logic [CNT_W-1:0] r_wait_cnt;
   logic [CNT_W-1:0] w_wait_next;
   logic             w_mem_state;
   logic             w_timeout;
   logic             w_branch_ok;
   logic             w_taken;
   logic             w_sub_ok;
   logic [3:0]       w_alu_dec;

   // Unqualified control values; gated with reset before leaving the block
   logic       w_mem_req;
   logic       w_pc_write;
   logic       w_adr_src;
   logic       w_mem_write;
   logic       w_ir_write;
   logic [1:0] w_result_src;
   logic [3:0] w_alu_ctrl;
   logic [1:0] w_src_a;
   logic [1:0] w_src_b;
   logic       w_reg_write;
   logic       w_trap;

   // The wait counter runs only in states that hold mem_req high
   assign w_mem_state = (r_state == c_FETCH) || (r_state == c_MEMREAD) ||
                        (r_state == c_MEMWRITE);
   assign w_timeout   = (MEM_TIMEOUT > 0) && w_mem_state && !mem_ready &&
                        (r_wait_cnt == c_TIMEOUT);
   assign w_wait_next = (w_mem_state && !mem_ready && !w_timeout) ?
                        (r_wait_cnt + 1'b1) : '0;

   // Branch funct3 010/011 are reserved encodings
   assign w_branch_ok = (funct3 != 3'b010) && (funct3 != 3'b011);

   // SUB is only reachable from register-register ops (ADDI has no SUBI)
   assign w_sub_ok = (r_state == c_EXECR);

   // State and wait-counter registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= c_FETCH;
         r_wait_cnt <= '0;
      end else begin
         r_state    <= w_state_next;
         r_wait_cnt <= w_wait_next;
      end
   end

   // Branch resolution from the flags of the rs1 - rs2 subtraction
   always_comb begin
      w_taken = 1'b0;
      case (funct3)
         3'b000:  w_taken = zero;
         3'b001:  w_taken = !zero;
         3'b100:  w_taken = negative ^ overflow;
         3'b101:  w_taken = !(negative ^ overflow);
         3'b110:  w_taken = !carryout;
         3'b111:  w_taken = carryout;
         default: w_taken = 1'b0;
      endcase
   end

   // ALU operation from funct3/funct7b5 for register and immediate ops
   always_comb begin
      w_alu_dec = c_ALU_ADD;
      case (funct3)
         3'b000: w_alu_dec = (w_sub_ok && funct7b5) ? c_ALU_SUB : c_ALU_ADD;
         3'b001: w_alu_dec = c_ALU_SLL;
         3'b010: w_alu_dec = c_ALU_SLT;
         3'b011: w_alu_dec = c_ALU_SLTU;
         3'b100: w_alu_dec = c_ALU_XOR;
         3'b101: w_alu_dec = funct7b5 ? c_ALU_SRA : c_ALU_SRL;
         3'b110: w_alu_dec = c_ALU_OR;
         3'b111: w_alu_dec = c_ALU_AND;
      endcase
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_FETCH: begin
            if (mem_ready)      w_state_next = c_DECODE;
            else if (w_timeout) w_state_next = c_TRAP;
         end
         c_DECODE: begin
            case (opcode)
               c_OP_LOAD,
               c_OP_STORE:  w_state_next = c_MEMADR;
               c_OP_R:      w_state_next = c_EXECR;
               c_OP_I:      w_state_next = c_EXECI;
               c_OP_BRANCH: w_state_next = w_branch_ok ? c_BRANCH : c_ILLEGAL_NEXT;
               c_OP_JAL:    w_state_next = c_JAL;
               c_OP_JALR:   w_state_next = c_JALR;
               c_OP_LUI:    w_state_next = c_LUI;
               c_OP_AUIPC:  w_state_next = c_AUIPC;
               default:     w_state_next = c_ILLEGAL_NEXT;
            endcase
         end
         c_MEMADR:
            w_state_next = (opcode == c_OP_LOAD) ? c_MEMREAD : c_MEMWRITE;
         c_MEMREAD: begin
            if (mem_ready)      w_state_next = c_MEMWB;
            else if (w_timeout) w_state_next = c_TRAP;
         end
         c_MEMWB:    w_state_next = c_FETCH;
         c_MEMWRITE: begin
            if (mem_ready)      w_state_next = c_FETCH;
            else if (w_timeout) w_state_next = c_TRAP;
         end
         c_EXECR:    w_state_next = c_ALUWB;
         c_EXECI:    w_state_next = c_ALUWB;
         c_ALUWB:    w_state_next = c_FETCH;
         c_BRANCH:   w_state_next = c_FETCH;
         c_JAL:      w_state_next = c_ALUWB;
         c_JALR:     w_state_next = c_JALRPC;
         c_JALRPC:   w_state_next = c_ALUWB;
         c_LUI:      w_state_next = c_ALUWB;
         c_AUIPC:    w_state_next = c_ALUWB;
         c_TRAP:     w_state_next = c_TRAP;
         default:    w_state_next = c_TRAP;
      endcase
   end

   // Per-state control values; strobes tied to mem_ready fire only on completion
   always_comb begin
      w_mem_req    = 1'b0;
      w_pc_write   = 1'b0;
      w_adr_src    = 1'b0;
      w_mem_write  = 1'b0;
      w_ir_write   = 1'b0;
      w_result_src = c_RES_ALUOUT;
      w_alu_ctrl   = c_ALU_ADD;
      w_src_a      = c_SRCA_PC;
      w_src_b      = c_SRCB_WD;
      w_reg_write  = 1'b0;
      w_trap       = 1'b0;
      case (r_state)
         c_FETCH: begin
            w_mem_req    = 1'b1;
            w_src_b      = c_SRCB_FOUR;
            w_result_src = c_RES_ALURES;
            w_ir_write   = mem_ready;
            w_pc_write   = mem_ready;
         end
         c_DECODE: begin
            w_src_a = c_SRCA_OLD;
            w_src_b = c_SRCB_IMM;
         end
         c_MEMADR: begin
            w_src_a = c_SRCA_RD1;
            w_src_b = c_SRCB_IMM;
         end
         c_MEMREAD: begin
            w_mem_req = 1'b1;
            w_adr_src = 1'b1;
         end
         c_MEMWB: begin
            w_result_src = c_RES_DATA;
            w_reg_write  = 1'b1;
         end
         c_MEMWRITE: begin
            w_mem_req   = 1'b1;
            w_adr_src   = 1'b1;
            w_mem_write = mem_ready;
         end
         c_EXECR: begin
            w_src_a    = c_SRCA_RD1;
            w_src_b    = c_SRCB_WD;
            w_alu_ctrl = w_alu_dec;
         end
         c_EXECI: begin
            w_src_a    = c_SRCA_RD1;
            w_src_b    = c_SRCB_IMM;
            w_alu_ctrl = w_alu_dec;
         end
         c_ALUWB: begin
            w_reg_write = 1'b1;
         end
         c_BRANCH: begin
            w_src_a    = c_SRCA_RD1;
            w_src_b    = c_SRCB_WD;
            w_alu_ctrl = c_ALU_SUB;
            w_pc_write = w_taken;
         end
         c_JAL: begin
            w_src_a    = c_SRCA_OLD;
            w_src_b    = c_SRCB_FOUR;
            w_pc_write = 1'b1;
         end
         c_JALR: begin
            w_src_a = c_SRCA_RD1;
            w_src_b = c_SRCB_IMM;
         end
         c_JALRPC: begin
            w_src_a    = c_SRCA_OLD;
            w_src_b    = c_SRCB_FOUR;
            w_pc_write = 1'b1;
         end
         c_LUI: begin
            w_src_a = c_SRCA_ZERO;
            w_src_b = c_SRCB_IMM;
         end
         c_AUIPC: begin
            w_src_a = c_SRCA_OLD;
            w_src_b = c_SRCB_IMM;
         end
         c_TRAP: begin
            w_trap = 1'b1;
         end
         default: begin
            w_trap = 1'b1;
         end
      endcase
   end

   // While reset is asserted every control output is held at its reset value,
   // so an access that completes in the reset cycle issues no strobe
   assign mem_req    = reset & w_mem_req;
   assign pc_write   = reset & w_pc_write;
   assign AdrSrc     = reset & w_adr_src;
   assign MemWrite   = reset & w_mem_write;
   assign IRWrite    = reset & w_ir_write;
   assign ResultSrc  = reset ? w_result_src : 2'b00;
   assign ALUControl = reset ? w_alu_ctrl   : 4'b0000;
   assign ALUSrca    = reset ? w_src_a      : 2'b00;
   assign ALUSrcb    = reset ? w_src_b      : 2'b00;
   assign RegWrite   = reset & w_reg_write;
   assign trap       = reset & w_trap;
   assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc_controller
//  Purpose  : Directed self-checking bench for mc_controller (MEM_TIMEOUT=4)
//  Revision : 1.0  initial release
// ============================================================================
module tb_mc_controller;

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADR   = 4'd2;
   localparam logic [3:0] S_MEMREAD  = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWRITE = 4'd5;
   localparam logic [3:0] S_EXECR    = 4'd6;
   localparam logic [3:0] S_EXECI    = 4'd7;
   localparam logic [3:0] S_ALUWB    = 4'd8;
   localparam logic [3:0] S_BRANCH   = 4'd9;
   localparam logic [3:0] S_JAL      = 4'd10;
   localparam logic [3:0] S_JALR     = 4'd11;
   localparam logic [3:0] S_JALRPC   = 4'd12;
   localparam logic [3:0] S_LUI      = 4'd13;
   localparam logic [3:0] S_TRAP     = 4'd15;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero, negative, carryout, overflow;
   logic       mem_ready;
   logic       mem_req, pc_write, AdrSrc, MemWrite, IRWrite, RegWrite, trap;
   logic [1:0] ResultSrc, ALUSrca, ALUSrcb;
   logic [3:0] ALUControl, state;
   logic [16:0] outs;

   int n_checks = 0;
   int n_errors = 0;

   mc_controller #(.MEM_TIMEOUT(4), .CNT_W(5)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
      .funct7b5(funct7b5), .zero(zero), .negative(negative),
      .carryout(carryout), .overflow(overflow), .mem_ready(mem_ready),
      .mem_req(mem_req), .pc_write(pc_write), .AdrSrc(AdrSrc),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
      .ALUControl(ALUControl), .ALUSrca(ALUSrca), .ALUSrcb(ALUSrcb),
      .RegWrite(RegWrite), .trap(trap), .state(state)
   );

   always #5 clk = ~clk;

   // All control outputs as one bus; trap is the LSB
   assign outs = {mem_req, pc_write, AdrSrc, MemWrite, IRWrite, ResultSrc,
                  ALUControl, ALUSrca, ALUSrcb, RegWrite, trap};

   task automatic check_val(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle and settle just after the falling edge
   task automatic adv();
      @(negedge clk);
      #1;
   endtask

   // From FETCH: an ALU instruction through DECODE, EXEC, ALUWB back to FETCH
   task automatic run_alu(input logic [6:0] op, input logic [2:0] f3,
                          input logic f7, input logic [3:0] exp_st,
                          input logic [3:0] exp_alu);
      opcode = op; funct3 = f3; funct7b5 = f7; mem_ready = 1'b1;
      adv();
      check_val("alu_decode", state, S_DECODE);
      adv();
      check_val("alu_exec_state", state, exp_st);
      check_val("alu_ctrl", ALUControl, exp_alu);
      adv();
      check_val("alu_wb_regwrite", {state, RegWrite}, {S_ALUWB, 1'b1});
      adv();
      check_val("alu_back_fetch", state, S_FETCH);
   endtask

   // From FETCH: a branch; pc_write must equal the expected taken value
   task automatic run_branch(input logic [2:0] f3, input logic z,
                             input logic n, input logic c, input logic v,
                             input logic exp_taken, input string tag);
      opcode = OP_BRANCH; funct3 = f3; mem_ready = 1'b1;
      zero = z; negative = n; carryout = c; overflow = v;
      adv();
      adv();
      check_val("br_state", state, S_BRANCH);
      check_val(tag, pc_write, exp_taken);
      check_val("br_alu_sub", ALUControl, 4'b0001);
      adv();
      check_val("br_back_fetch", state, S_FETCH);
   endtask

   // Synchronous reset pulse; leaves the FSM in FETCH with reset released
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      adv();
      check_val("rst_state", state, S_FETCH);
      reset = 1'b1;
      #1;
   endtask

   initial begin
      int n_req;
      reset = 1'b0; opcode = OP_R; funct3 = 3'b000; funct7b5 = 1'b0;
      zero = 1'b0; negative = 1'b0; carryout = 1'b0; overflow = 1'b0;
      mem_ready = 1'b1;

      // Reset held: state FETCH, all outputs zero even with mem_ready high
      adv();
      check_val("reset_state", state, S_FETCH);
      check_val("reset_outs", outs, 17'h0);
      reset = 1'b1;
      #1;

      // R-type ADD walk with per-state outputs
      check_val("fetch_outs", outs,
                {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 4'b0000, 2'b00, 2'b10, 1'b0, 1'b0});
      adv();
      check_val("decode_state", state, S_DECODE);
      check_val("decode_srcs", {ALUSrca, ALUSrcb, RegWrite}, {2'b01, 2'b01, 1'b0});
      adv();
      check_val("execr_state", state, S_EXECR);
      check_val("execr_add", {ALUControl, ALUSrca, ALUSrcb, RegWrite},
                {4'b0000, 2'b10, 2'b00, 1'b0});
      adv();
      check_val("aluwb", {state, RegWrite, ResultSrc}, {S_ALUWB, 1'b1, 2'b00});
      adv();
      check_val("r_done_fetch", {state, RegWrite}, {S_FETCH, 1'b0});

      // ALU decode variants
      run_alu(OP_R, 3'b000, 1'b1, S_EXECR, 4'b0001);   // SUB
      run_alu(OP_R, 3'b101, 1'b1, S_EXECR, 4'b0111);   // SRA
      run_alu(OP_R, 3'b011, 1'b0, S_EXECR, 4'b1001);   // SLTU
      run_alu(OP_I, 3'b000, 1'b1, S_EXECI, 4'b0000);   // ADDI ignores funct7b5
      run_alu(OP_I, 3'b101, 1'b1, S_EXECI, 4'b0111);   // SRAI
      run_alu(OP_I, 3'b111, 1'b0, S_EXECI, 4'b0010);   // ANDI
      run_alu(OP_LUI, 3'b000, 1'b0, S_LUI, 4'b0000);

      // Load with three wait cycles in MEMREAD; MEMWB on cycle 8
      opcode = OP_LOAD; funct3 = 3'b010; mem_ready = 1'b1;   // cycle 1 FETCH
      adv();                                                  // cycle 2
      adv();                                                  // cycle 3
      check_val("ld_memadr", {state, ALUSrca, ALUSrcb}, {S_MEMADR, 2'b10, 2'b01});
      n_req = 0;
      for (int i = 0; i < 4; i++) begin                       // cycles 4..7
         @(negedge clk);
         mem_ready = (i == 3);
         #1;
         check_val("ld_memread", {state, AdrSrc, RegWrite}, {S_MEMREAD, 1'b1, 1'b0});
         if (mem_req) n_req++;
      end
      check_val("ld_req_cycles", n_req, 4);
      adv();                                                  // cycle 8
      check_val("ld_memwb", {state, ResultSrc, RegWrite}, {S_MEMWB, 2'b01, 1'b1});
      adv();
      check_val("ld_done", state, S_FETCH);

      // Store with immediate completion: 4 cycles, MemWrite in MEMWRITE
      opcode = OP_STORE;
      adv();
      adv();
      adv();
      check_val("st_memwrite", {state, mem_req, AdrSrc, MemWrite},
                {S_MEMWRITE, 1'b1, 1'b1, 1'b1});
      adv();
      check_val("st_done", state, S_FETCH);

      // Branches
      run_branch(3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "bltu_c0_taken");
      opcode = OP_BRANCH; funct3 = 3'b110; carryout = 1'b0;
      adv();
      adv();
      carryout = 1'b1;
      #1;
      check_val("bltu_c1_not_taken", {state, pc_write}, {S_BRANCH, 1'b0});
      adv();
      run_branch(3'b101, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "bge_n1v1_taken");
      run_branch(3'b101, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "bge_n1v0_not");
      run_branch(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "beq_z1_taken");
      run_branch(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "bne_z1_not");
      run_branch(3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "bgeu_c1_taken");

      // JAL then JALR
      opcode = OP_JAL;
      adv();
      adv();
      check_val("jal", {state, pc_write, ALUSrca, ALUSrcb}, {S_JAL, 1'b1, 2'b01, 2'b10});
      adv();
      check_val("jal_wb", {state, RegWrite}, {S_ALUWB, 1'b1});
      adv();
      opcode = OP_JALR; funct3 = 3'b000;
      adv();
      adv();
      check_val("jalr", {state, pc_write, ALUSrca, ALUSrcb}, {S_JALR, 1'b0, 2'b10, 2'b01});
      adv();
      check_val("jalrpc", {state, pc_write, ALUSrca, ALUSrcb}, {S_JALRPC, 1'b1, 2'b01, 2'b10});
      adv();
      check_val("jalr_wb", state, S_ALUWB);
      adv();
      check_val("jalr_done", state, S_FETCH);

      // Illegal opcode
      opcode = 7'h7F;
      adv();
      adv();
`ifdef ILLEGAL_TRAP_EN
      check_val("illegal_trap", {state, trap}, {S_TRAP, 1'b1});
      do_reset();
`else
      check_val("illegal_nop", {state, trap}, {S_FETCH, 1'b0});
`endif

      // Timeout: mem_ready stuck low in FETCH; 4 waits allowed, 5th cycle traps
      opcode = OP_R;
      mem_ready = 1'b0;
      #1;
      check_val("to_fetch0", {state, IRWrite}, {S_FETCH, 1'b0});
      for (int i = 0; i < 4; i++) begin
         adv();
         check_val("to_fetch_wait", {state, IRWrite, pc_write}, {S_FETCH, 1'b0, 1'b0});
      end
      adv();
      check_val("to_trap_state", state, S_TRAP);
      check_val("to_trap_outs", outs, 17'h1);
      mem_ready = 1'b1;
      adv();
      check_val("to_trap_held", {state, outs}, {S_TRAP, 17'h1});
      do_reset();

      // Reset during a MEMWRITE wait
      opcode = OP_STORE; mem_ready = 1'b1;
      adv();
      adv();
      adv();
      mem_ready = 1'b0;
      #1;
      check_val("rw_wait", {state, mem_req, MemWrite}, {S_MEMWRITE, 1'b1, 1'b0});
      adv();
      check_val("rw_wait2", {state, MemWrite}, {S_MEMWRITE, 1'b0});
      reset = 1'b0;
      mem_ready = 1'b1;
      #1;
      check_val("rw_rst_no_strobe", outs, 17'h0);
      adv();
      check_val("rw_rst_fetch", {state, outs}, {S_FETCH, 17'h0});
      reset = 1'b1;
      #1;
      check_val("rw_after_release", {mem_req, IRWrite}, 2'b11);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
